// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with a valid/ready input handshake.
// Frame: start(0), DATA_W data bits LSB first, optional parity, one or two stop bits.
// Parity mode per word: 00 none, 01 even, 10 odd, 11 none.
// Optional feature macro: UART_TX_FIFO_EN adds a FIFO_DEPTH-entry input FIFO so
// that consecutive frames run back-to-back without an idle cycle.
module uart_tx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  output logic              Tx_out,
  output logic              tx_busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_W);
  localparam int WORD_W = DATA_W + 3;

  // Elaboration-time parameter sanity checks.
  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_param: DATA_W must be in 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_param: CLKS_PER_BIT must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of 2, at least 2");
  end

  logic [2:0]        state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_en;
  logic              par_bit;
  logic              stop2;

  logic              baud_tick;
  logic              stop_done;
  logic              word_avail;
  logic [WORD_W-1:0] word;
  logic              chain;
  logic              load;

  logic [DATA_W-1:0] wd_data;
  logic              wd_two;
  logic [1:0]        wd_mode;

  assign baud_tick = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  // Last cycle of the final stop bit: the frame ends on this edge.
  assign stop_done = (state == STOP) && baud_tick &&
                     (bit_cnt == {{(BIT_W-1){1'b0}}, stop2});

  // Word layout is {parity_mode, two_stop, data}.
  assign wd_data = word[DATA_W-1:0];
  assign wd_two  = word[DATA_W];
  assign wd_mode = word[DATA_W+2:DATA_W+1];

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              push;
  logic              pop;

  assign tx_ready   = (count != (PTR_W+1)'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign word_avail = (count != '0);
  assign word       = mem[rd_ptr];
  assign chain      = stop_done;
  assign pop        = load;

  // FIFO storage write port.
  // NOTE: the storage array has no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {parity_mode, two_stop, tx_data};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end
`else
  assign tx_ready   = (state == IDLE);
  assign word_avail = tx_valid;
  assign word       = {parity_mode, two_stop, tx_data};
  assign chain      = 1'b0;
`endif

  // A new frame starts from IDLE, or straight out of STOP when chaining is possible.
  assign load    = word_avail && ((state == IDLE) || chain);
  assign tx_busy = (state != IDLE);

  // Frame sequencer: captures the word, paces bits with the baud counter, drives the line.
  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      stop2    <= 1'b0;
      Tx_out   <= 1'b1;
    end else if (load) begin
      state    <= START;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= wd_data;
      par_en   <= (wd_mode == 2'b01) || (wd_mode == 2'b10);
      par_bit  <= (^wd_data) ^ (wd_mode == 2'b10);
      stop2    <= wd_two;
      Tx_out   <= 1'b0;
    end else if (state != IDLE) begin
      if (!baud_tick) begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end else begin
        baud_cnt <= '0;
        case (state)
          START: begin
            state   <= DATA;
            bit_cnt <= '0;
            Tx_out  <= shreg[0];
            shreg   <= shreg >> 1;
          end
          DATA: begin
            if (bit_cnt == BIT_W'(DATA_W - 1)) begin
              bit_cnt <= '0;
              if (par_en) begin
                state  <= PARITY;
                Tx_out <= par_bit;
              end else begin
                state  <= STOP;
                Tx_out <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              Tx_out  <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
          PARITY: begin
            state   <= STOP;
            bit_cnt <= '0;
            Tx_out  <= 1'b1;
          end
          STOP: begin
            if (stop_done) begin
              state   <= IDLE;
              bit_cnt <= '0;
              Tx_out  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
          default: begin
            state  <= IDLE;
            Tx_out <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: self-checking bench for uart_tx_param (DATA_W=8, CLKS_PER_BIT=4).
// A frame-level reference model predicts Tx_out, tx_busy and tx_ready every cycle;
// directed tests pin the model and the design against hand-computed frames.
// Builds with or without UART_TX_FIFO_EN.
module tb_uart_tx_param;

  localparam int DW    = 8;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_FIFO_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [1:0]    parity_mode;
  logic          two_stop;
  logic          Tx_out;
  logic          tx_busy;

  always #5 clk = ~clk;

  uart_tx_param #(
    .DATA_W      (DW),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .parity_mode(parity_mode),
    .two_stop   (two_stop),
    .Tx_out     (Tx_out),
    .tx_busy    (tx_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]    pm;
    logic          ts;
    logic [DW-1:0] d;
  } word_t;

  bit          m_init    = 1'b0;
  bit          m_active  = 1'b0;
  int          m_pos     = 0;
  int          m_len     = 0;
  int          m_acc     = 0;
  int          m_acc_cyc = 0;
  int          cyc       = 0;
  logic [15:0] m_frame   = '1;
  bit          m_xfer;
  word_t       m_in;
`ifdef UART_TX_FIFO_EN
  word_t       m_q[$];
`endif

  // Serial bit sequence of one frame, bit i = i-th bit on the line; stop bits and beyond are 1.
  function automatic logic [15:0] build_frame(input logic [DW-1:0] d, input logic [1:0] pm,
                                              input logic ts, output int nbits);
    logic [15:0] f;
    bit par_on;
    par_on = (pm == 2'b01) || (pm == 2'b10);
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DW; i++) f[i+1] = d[i];
    if (par_on) f[DW+1] = (pm == 2'b10) ? ~(^d) : (^d);
    nbits = 1 + DW + (par_on ? 1 : 0) + (ts ? 2 : 1);
    return f;
  endfunction

  function automatic bit m_ready_now();
`ifdef UART_TX_FIFO_EN
    return m_q.size() < DEPTH;
`else
    return !m_active;
`endif
  endfunction

  function automatic void start_frame(input word_t w);
    int nb;
    m_frame  = build_frame(w.d, w.pm, w.ts, nb);
    m_len    = nb * CPB;
    m_pos    = 0;
    m_active = 1'b1;
  endfunction

  // Model update on each rising edge from the inputs the DUT also sees.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_init   = 1'b1;
      m_active = 1'b0;
      m_pos    = 0;
`ifdef UART_TX_FIFO_EN
      m_q.delete();
`endif
    end else if (m_init) begin
      m_xfer  = tx_valid && m_ready_now();
      m_in.pm = parity_mode;
      m_in.ts = two_stop;
      m_in.d  = tx_data;
`ifdef UART_TX_FIFO_EN
      if (m_active && m_pos < m_len - 1) m_pos++;
      else if (m_q.size() > 0)           start_frame(m_q.pop_front());
      else                               m_active = 1'b0;
      if (m_xfer) m_q.push_back(m_in);
`else
      if (m_active) begin
        m_pos++;
        if (m_pos == m_len) m_active = 1'b0;
      end else if (m_xfer) begin
        start_frame(m_in);
      end
`endif
      if (m_xfer) begin
        m_acc++;
        m_acc_cyc = cyc;
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      check("tx_out",   Tx_out,   m_active ? m_frame[m_pos / CPB] : 1'b1);
      check("tx_busy",  tx_busy,  m_active);
      check("tx_ready", tx_ready, m_ready_now());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [DW-1:0] d, input logic [1:0] pm, input logic ts,
                      input bit hold_valid);
    int start;
    int budget;
    start       = m_acc;
    budget      = 0;
    tx_data     = d;
    parity_mode = pm;
    two_stop    = ts;
    tx_valid    = 1'b1;
    do begin
      @(negedge clk);
      budget++;
    end while (m_acc == start && budget < 300);
    check("accept_timeout", m_acc != start, 1);
    if (!hold_valid) tx_valid = 1'b0;
  endtask

  // Samples each bit mid-period from the first frame cycle and counts busy cycles.
  task automatic capture(output logic [15:0] bits, output int busy_cyc);
    int c;
    c    = 0;
    bits = '1;
    repeat (LAT) @(negedge clk);
    while (tx_busy && c < 100) begin
      if (c % CPB == 1 && c / CPB < 16) bits[c / CPB] = Tx_out;
      c++;
      @(negedge clk);
    end
    busy_cyc = c;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while ((m_active || !m_ready_now() || tx_valid) && budget < 1000) begin
      tx_valid = 1'b0;
      @(negedge clk);
      budget++;
    end
    check("idle_timeout", budget < 1000, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] bits;
    logic [15:0] f;
    int          busy;
    int          nb;
    int          c1;

    reset       = 1'b1;
    tx_valid    = 1'b0;
    tx_data     = '0;
    parity_mode = 2'b00;
    two_stop    = 1'b0;

    // Pin the model's frame builder against hand-computed frames.
    f = build_frame(8'hA5, 2'b00, 1'b0, nb);
    check("model_a5_frame", f[9:0], 10'h34A);
    check("model_a5_len", nb, 10);
    f = build_frame(8'h07, 2'b01, 1'b0, nb);
    check("model_even_par", f[9], 1'b1);
    check("model_even_len", nb, 11);
    f = build_frame(8'h07, 2'b10, 1'b1, nb);
    check("model_odd_par", f[9], 1'b0);
    check("model_par_2stop_len", nb, 12);

    repeat (3) @(negedge clk);
    check("reset_tx_out",   Tx_out,   1'b1);
    check("reset_tx_busy",  tx_busy,  1'b0);
    check("reset_tx_ready", tx_ready, 1'b1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 0xA5, no parity, one stop: 0,1,0,1,0,0,1,0,1,1 over 40 cycles.
    send(8'hA5, 2'b00, 1'b0, 1'b0);
    capture(bits, busy);
    check("a5_bits", bits[9:0], 10'h34A);
    check("a5_cycles", busy, 40);

    // Even and odd parity on 0x07.
    send(8'h07, 2'b01, 1'b0, 1'b0);
    capture(bits, busy);
    check("even_parity_bit", bits[9], 1'b1);
    check("even_cycles", busy, 44);
    send(8'h07, 2'b10, 1'b0, 1'b0);
    capture(bits, busy);
    check("odd_parity_bit", bits[9], 1'b0);

    // Parity plus two stop bits: 12 bits, 48 cycles.
    send(8'h07, 2'b01, 1'b1, 1'b0);
    capture(bits, busy);
    check("two_stop_bits", bits[11:9], 3'b111);
    check("two_stop_cycles", busy, 48);

    // Inputs changed right after acceptance must not alter the frame in flight.
    send(8'h07, 2'b01, 1'b0, 1'b0);
    parity_mode = 2'b10;
    tx_data     = 8'hF0;
    two_stop    = 1'b1;
    capture(bits, busy);
    check("inflight_parity", bits[9], 1'b1);
    check("inflight_data", bits[8:1], 8'h07);
    check("inflight_cycles", busy, 44);

    // tx_valid held across two words.
    send(8'h01, 2'b00, 1'b0, 1'b1);
    c1 = m_acc_cyc;
    send(8'h02, 2'b00, 1'b0, 1'b0);
    check("held_valid_spacing", m_acc_cyc - c1, (LAT == 1) ? 1 : 41);
    wait_idle();

    // Reset during data bit 3 of 0xFF, then a clean frame.
    send(8'hFF, 2'b00, 1'b0, 1'b0);
    repeat (17 + LAT) @(negedge clk);
    check("pre_reset_busy", tx_busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_tx_out",  Tx_out,  1'b1);
    check("abort_tx_busy", tx_busy, 1'b0);
    @(negedge clk);
    send(8'hA5, 2'b00, 1'b0, 1'b0);
    capture(bits, busy);
    check("post_reset_bits", bits[9:0], 10'h34A);
    check("post_reset_cycles", busy, 40);

`ifdef UART_TX_FIFO_EN
    // Five words pushed back-to-back: contiguous frames, 200 busy cycles in total.
    begin
      int first;
      int budget;
      send(8'h11, 2'b00, 1'b0, 1'b1);
      first = m_acc_cyc;
      send(8'h22, 2'b00, 1'b0, 1'b1);
      send(8'h33, 2'b00, 1'b0, 1'b1);
      send(8'h44, 2'b00, 1'b0, 1'b1);
      send(8'h55, 2'b00, 1'b0, 1'b0);
      check("fifo_full_ready", tx_ready, 1'b0);
      budget = 0;
      while (tx_busy && budget < 400) begin
        @(negedge clk);
        budget++;
      end
      check("fifo_contiguous_end", cyc, first + 201);
    end
`endif

    // Randomized words, modes, gaps, in-flight input changes and occasional resets.
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(DW'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0);
      tx_data     = DW'($urandom);
      parity_mode = 2'($urandom_range(0, 3));
      two_stop    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) begin
        repeat ($urandom_range(0, 40)) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    tx_valid = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #800000;
    check("global_timeout", 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
